// File: rtl/nios2_oci_dct_packer_pkg.sv
// Shared trace parameters, atom encodings and slot-placement helper
// for the OCI compressed-trace (DCT) producer.
package nios2_oci_trace_pkg;

    localparam int unsigned ATOM_W = 2;
    localparam int unsigned ATOMS  = 15;
    localparam int unsigned BUF_W  = ATOM_W * ATOMS;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] ATOMS_CNT = CNT_W'(ATOMS);

    typedef logic [ATOM_W-1:0] atom_t;
    typedef logic [BUF_W-1:0]  dct_buf_t;
    typedef logic [CNT_W-1:0]  dct_cnt_t;

    typedef enum logic [ATOM_W-1:0] {
        ATOM_NONE = 2'b00,
        ATOM_NT   = 2'b01,
        ATOM_T    = 2'b10,
        ATOM_EXC  = 2'b11
    } atom_code_e;

    // Position an atom at its slot; slot 0 sits at the LSB.
    function automatic dct_buf_t place_atom(input atom_t atom, input dct_cnt_t slot);
        return BUF_W'(atom) << (slot * ATOM_W);
    endfunction

endpackage

// File: rtl/nios2_oci_dct_packer_if.sv
// Word-level valid/ready channel between the packer and the trace FIFO.
interface nios2_oci_dct_packer_if;
    import nios2_oci_trace_pkg::*;

    logic     dct_valid;
    logic     dct_ready;
    dct_buf_t dct_buffer;
    dct_cnt_t dct_count;

    modport master (
        output dct_valid,
        output dct_buffer,
        output dct_count,
        input  dct_ready
    );

    modport slave (
        input  dct_valid,
        input  dct_buffer,
        input  dct_count,
        output dct_ready
    );

endinterface

// File: rtl/nios2_oci_dct_packer_outreg.sv
// Single-entry valid/ready holding register for finished DCT words.
module nios2_oci_dct_outreg
    import nios2_oci_trace_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  dct_buf_t load_buf,
    input  dct_cnt_t load_cnt,
    output logic     out_free,
    nios2_oci_dct_packer_if.master dct
);

    assign out_free = !dct.dct_valid || dct.dct_ready;

    // Hold the word until accepted; a load replaces it on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            dct.dct_valid  <= 1'b0;
            dct.dct_buffer <= '0;
            dct.dct_count  <= '0;
        end else if (load) begin
            dct.dct_valid  <= 1'b1;
            dct.dct_buffer <= load_buf;
            dct.dct_count  <= load_cnt;
        end else if (dct.dct_ready) begin
            dct.dct_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT words; accumulator, flush and
// overflow control live here, the output stage in nios2_oci_dct_outreg.
module nios2_oci_dct_packer
    import nios2_oci_trace_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  atom_valid,
    input  atom_t atom_data,
    input  logic  flush,
    input  logic  overflow_clr,
    output logic  overflow,
    nios2_oci_dct_packer_if.master dct
);

    dct_buf_t acc_buf, acc_buf_nxt, merged_buf, load_buf;
    dct_cnt_t acc_cnt, acc_cnt_nxt, merged_cnt, load_cnt;
    logic     flush_pend, flush_pend_nxt;
    logic     acc_full, take, load, drop, out_free, flush_req;

    nios2_oci_dct_outreg u_outreg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_buf (load_buf),
        .load_cnt (load_cnt),
        .out_free (out_free),
        .dct      (dct)
    );

    // Accept/transfer/drop decision for the accumulator this cycle.
    always_comb begin
        acc_full   = (acc_cnt == ATOMS_CNT);
        flush_req  = flush || flush_pend;
        take       = atom_valid && !flush_pend && !acc_full;
        merged_buf = acc_buf;
        merged_cnt = acc_cnt;
        if (take) begin
            merged_buf = acc_buf | place_atom(atom_data, acc_cnt);
            merged_cnt = acc_cnt + 1'b1;
        end
        acc_buf_nxt    = merged_buf;
        acc_cnt_nxt    = merged_cnt;
        flush_pend_nxt = 1'b0;
        load           = 1'b0;
        load_buf       = merged_buf;
        load_cnt       = merged_cnt;
        drop           = atom_valid && !take;

        if (acc_full) begin
            // A held full word leaves first; a fresh atom restarts at slot 0.
            load_buf = acc_buf;
            load_cnt = acc_cnt;
            if (out_free) begin
                load = 1'b1;
                if (atom_valid && !flush_pend) begin
                    acc_buf_nxt    = place_atom(atom_data, '0);
                    acc_cnt_nxt    = CNT_W'(1);
                    flush_pend_nxt = flush;
                    drop           = 1'b0;
                end else begin
                    acc_buf_nxt = '0;
                    acc_cnt_nxt = '0;
                end
            end else begin
                flush_pend_nxt = flush_req;
            end
        end else if ((merged_cnt == ATOMS_CNT) || (flush_req && (merged_cnt != '0))) begin
            if (out_free) begin
                load        = 1'b1;
                acc_buf_nxt = '0;
                acc_cnt_nxt = '0;
            end else begin
                flush_pend_nxt = flush_req;
            end
        end
    end

    // Accumulator, pending-flush and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_buf    <= '0;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            acc_buf    <= acc_buf_nxt;
            acc_cnt    <= acc_cnt_nxt;
            flush_pend <= flush_pend_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
